// File: rtl/combat_judge.sv
// rtl/combat_judge.sv - per-frame hit resolver: overlap, damage, hitstun/hitstop timers, KO/draw
module combat_judge #(
    parameter logic [7:0] MAX_HEALTH     = 8'd100,
    parameter logic [7:0] DAMAGE         = 8'd10,
    parameter logic [3:0] HITSTOP_FRAMES = 4'd4,
    parameter logic [5:0] HITSTUN_FRAMES = 6'd20,
    parameter logic [3:0] ACTIVE_STATE   = 4'd4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_tick_i,
    input  logic       restart_i,
    input  logic [3:0] p1_state_i,
    input  logic [3:0] p2_state_i,
    input  logic [9:0] p1_hit_x1_i,
    input  logic [9:0] p1_hit_x2_i,
    input  logic [9:0] p1_hit_y1_i,
    input  logic [9:0] p1_hit_y2_i,
    input  logic [9:0] p2_hit_x1_i,
    input  logic [9:0] p2_hit_x2_i,
    input  logic [9:0] p2_hit_y1_i,
    input  logic [9:0] p2_hit_y2_i,
    input  logic [9:0] p1_hurt_x1_i,
    input  logic [9:0] p1_hurt_x2_i,
    input  logic [9:0] p1_hurt_y1_i,
    input  logic [9:0] p1_hurt_y2_i,
    input  logic [9:0] p2_hurt_x1_i,
    input  logic [9:0] p2_hurt_x2_i,
    input  logic [9:0] p2_hurt_y1_i,
    input  logic [9:0] p2_hurt_y2_i,
    output logic [7:0] p1_health_o,
    output logic [7:0] p2_health_o,
    output logic       p1_stunned_o,
    output logic       p2_stunned_o,
    output logic       p1_hit_o,
    output logic       p2_hit_o,
    output logic       freeze_o,
    output logic [1:0] winner_o,
    output logic       round_over_o
);

    localparam logic [1:0] ST_FIGHT  = 2'd0;
    localparam logic [1:0] ST_FREEZE = 2'd1;
    localparam logic [1:0] ST_KO     = 2'd2;

    logic [1:0] state_q, state_d;
    logic [7:0] p1_health_q, p1_health_d, p2_health_q, p2_health_d;
    logic [5:0] p1_stun_q, p1_stun_d, p2_stun_q, p2_stun_d;
    logic [3:0] hitstop_q, hitstop_d;
    logic       p1_conn_q, p1_conn_d, p2_conn_q, p2_conn_d;
    logic       p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
    logic [1:0] winner_q, winner_d;

    logic [5:0] p1_stun_dec, p2_stun_dec;
    logic       p1_lands, p2_lands;

    // Inclusive bounds: boxes sharing an edge pixel count as touching.
    function automatic logic overlap(
        input logic [9:0] ax1, input logic [9:0] ax2, input logic [9:0] ay1, input logic [9:0] ay2,
        input logic [9:0] bx1, input logic [9:0] bx2, input logic [9:0] by1, input logic [9:0] by2
    );
        return (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);
    endfunction

    function automatic logic [7:0] take_damage(input logic [7:0] h);
        return (h < DAMAGE) ? 8'd0 : h - DAMAGE;
    endfunction

    always_comb begin
        p1_stun_dec = (p1_stun_q != 6'd0) ? p1_stun_q - 6'd1 : 6'd0;
        p2_stun_dec = (p2_stun_q != 6'd0) ? p2_stun_q - 6'd1 : 6'd0;

        // A victim whose stun expires on this very tick is already hittable again.
        p1_lands = (p1_state_i == ACTIVE_STATE) && !p1_conn_q && (p2_stun_dec == 6'd0) &&
                   overlap(p1_hit_x1_i, p1_hit_x2_i, p1_hit_y1_i, p1_hit_y2_i,
                           p2_hurt_x1_i, p2_hurt_x2_i, p2_hurt_y1_i, p2_hurt_y2_i);
        p2_lands = (p2_state_i == ACTIVE_STATE) && !p2_conn_q && (p1_stun_dec == 6'd0) &&
                   overlap(p2_hit_x1_i, p2_hit_x2_i, p2_hit_y1_i, p2_hit_y2_i,
                           p1_hurt_x1_i, p1_hurt_x2_i, p1_hurt_y1_i, p1_hurt_y2_i);
    end

    always_comb begin
        state_d     = state_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        p1_stun_d   = p1_stun_q;
        p2_stun_d   = p2_stun_q;
        hitstop_d   = hitstop_q;
        p1_conn_d   = p1_conn_q;
        p2_conn_d   = p2_conn_q;
        winner_d    = winner_q;
        p1_hit_d    = 1'b0;
        p2_hit_d    = 1'b0;

        if (frame_tick_i) begin
            if (p1_state_i != ACTIVE_STATE) p1_conn_d = 1'b0;
            if (p2_state_i != ACTIVE_STATE) p2_conn_d = 1'b0;
        end

        case (state_q)
            ST_FIGHT: begin
                if (frame_tick_i) begin
                    p1_stun_d = p1_stun_dec;
                    p2_stun_d = p2_stun_dec;
                    if (p1_lands) begin
                        p2_health_d = take_damage(p2_health_q);
                        p2_stun_d   = HITSTUN_FRAMES;
                        p2_hit_d    = 1'b1;
                        p1_conn_d   = 1'b1;
                    end
                    if (p2_lands) begin
                        p1_health_d = take_damage(p1_health_q);
                        p1_stun_d   = HITSTUN_FRAMES;
                        p1_hit_d    = 1'b1;
                        p2_conn_d   = 1'b1;
                    end
                    if (p1_health_d == 8'd0 || p2_health_d == 8'd0) begin
                        state_d  = ST_KO;
                        winner_d = {p1_health_d == 8'd0, p2_health_d == 8'd0};
                    end else if (p1_lands || p2_lands) begin
                        state_d   = ST_FREEZE;
                        hitstop_d = HITSTOP_FRAMES;
                    end
                end
            end
            ST_FREEZE: begin
                if (frame_tick_i) begin
                    if (hitstop_q <= 4'd1) begin
                        hitstop_d = 4'd0;
                        state_d   = ST_FIGHT;
                    end else begin
                        hitstop_d = hitstop_q - 4'd1;
                    end
                end
            end
            ST_KO: begin
                if (restart_i) begin
                    state_d     = ST_FIGHT;
                    p1_health_d = MAX_HEALTH;
                    p2_health_d = MAX_HEALTH;
                    p1_stun_d   = 6'd0;
                    p2_stun_d   = 6'd0;
                    hitstop_d   = 4'd0;
                    p1_conn_d   = 1'b0;
                    p2_conn_d   = 1'b0;
                    winner_d    = 2'b00;
                end
            end
            default: state_d = ST_FIGHT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_FIGHT;
            p1_health_q <= MAX_HEALTH;
            p2_health_q <= MAX_HEALTH;
            p1_stun_q   <= 6'd0;
            p2_stun_q   <= 6'd0;
            hitstop_q   <= 4'd0;
            p1_conn_q   <= 1'b0;
            p2_conn_q   <= 1'b0;
            p1_hit_q    <= 1'b0;
            p2_hit_q    <= 1'b0;
            winner_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            p1_stun_q   <= p1_stun_d;
            p2_stun_q   <= p2_stun_d;
            hitstop_q   <= hitstop_d;
            p1_conn_q   <= p1_conn_d;
            p2_conn_q   <= p2_conn_d;
            p1_hit_q    <= p1_hit_d;
            p2_hit_q    <= p2_hit_d;
            winner_q    <= winner_d;
        end
    end

    assign p1_health_o  = p1_health_q;
    assign p2_health_o  = p2_health_q;
    assign p1_stunned_o = (p1_stun_q != 6'd0);
    assign p2_stunned_o = (p2_stun_q != 6'd0);
    assign p1_hit_o     = p1_hit_q;
    assign p2_hit_o     = p2_hit_q;
    assign freeze_o     = (state_q == ST_FREEZE) || (state_q == ST_KO);
    assign winner_o     = winner_q;
    assign round_over_o = (state_q == ST_KO);

endmodule
